// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state encoding and byte-merge helper
// for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: write-first forwarding, zero-register and
// clear masking, then the output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   mem_val,
  input  logic                clearing,
  input  logic                w0_ok,
  input  logic [ADDR_W-1:0]   w0_addr,
  input  logic [DATA_W-1:0]   w0_data,
  input  logic [DATA_W/8-1:0] w0_be,
  input  logic                w1_ok,
  input  logic [ADDR_W-1:0]   w1_addr,
  input  logic [DATA_W-1:0]   w1_data,
  input  logic [DATA_W/8-1:0] w1_be,
  output logic [DATA_W-1:0]   data_p1
);

  localparam int NBE = DATA_W / 8;

  logic [DATA_W-1:0] data_p0;

  always_comb begin
    data_p0 = mem_val;
    if (BYPASS != 0) begin
      // Port 1 overlays after port 0 so it wins on shared bytes.
      if (w0_ok && (w0_addr == addr))
        for (int b = 0; b < NBE; b++)
          data_p0[b*8 +: 8] = merge_byte(data_p0[b*8 +: 8], w0_data[b*8 +: 8], w0_be[b]);
      if (w1_ok && (w1_addr == addr))
        for (int b = 0; b < NBE; b++)
          data_p0[b*8 +: 8] = merge_byte(data_p0[b*8 +: 8], w1_data[b*8 +: 8], w1_be[b]);
    end
    if (clearing || ((ZERO_REG != 0) && (addr == '0)))
      data_p0 = '0;
  end

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_p1 <= '0;
    else      data_p1 <= data_p0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-enabled write ports, NUM_RD registered
// read ports, optional zero register and a sequenced bulk-clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [DATA_W/8-1:0]      wr0_be,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [DATA_W/8-1:0]      wr1_be,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBE   = DATA_W / 8;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];
  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              w0_ok, w1_ok;

  // Writes are suppressed while clearing and when they target the zero register.
  assign w0_ok = wr0_en && !clearing && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign w1_ok = wr1_en && !clearing && !((ZERO_REG != 0) && (wr1_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clearing = (state == CLEAR);
    clr_busy = clearing;
  end

  // Counter returns to zero exactly when the last entry is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clearing) cnt <= cnt + 1'b1;
    else               cnt <= '0;
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_nxt[e] = mem[e];
      if (clearing) begin
        if (cnt == ADDR_W'(e)) mem_nxt[e] = '0;
      end else begin
        if (w0_ok && (wr0_addr == ADDR_W'(e)))
          for (int b = 0; b < NBE; b++)
            mem_nxt[e][b*8 +: 8] = merge_byte(mem_nxt[e][b*8 +: 8], wr0_data[b*8 +: 8], wr0_be[b]);
        if (w1_ok && (wr1_addr == ADDR_W'(e)))
          for (int b = 0; b < NBE; b++)
            mem_nxt[e][b*8 +: 8] = merge_byte(mem_nxt[e][b*8 +: 8], wr1_data[b*8 +: 8], wr1_be[b]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= mem_nxt[e];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
      .mem_val  (mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .clearing (clearing),
      .w0_ok    (w0_ok),
      .w0_addr  (wr0_addr),
      .w0_data  (wr0_data),
      .w0_be    (wr0_be),
      .w1_ok    (w1_ok),
      .w1_addr  (wr1_addr),
      .w1_data  (wr1_data),
      .w1_be    (wr1_be),
      .data_p1  (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a write-first instance and a read-first
// instance share the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_rf;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [3:0]  wr0_be, wr1_be;
  logic        clr_req;
  logic        clr_busy, clr_busy_rf;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_rf (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_rf),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .clr_req(clr_req), .clr_busy(clr_busy_rf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_be = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_be = '0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_addr = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy act=%b exp=0", clr_busy); end
    total++;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd act=%h exp=0", rd_data); end
    rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      total++;
      if (rd_data !== 64'h0) begin
        bad++; $display("FAIL reset_read a=%0d act=%h exp=0", a, rd_data);
      end
    end
  endtask

  task automatic test_bypass();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF;
    rd_addr = {5'd0, 5'd5};
    tick();
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_wf act=%h exp=deadbeef", rd_data[31:0]);
    end
    total++;
    if (rd_data_rf[31:0] !== 32'h0) begin
      bad++; $display("FAIL bypass_rf_first act=%h exp=0", rd_data_rf[31:0]);
    end
    idle_inputs();
    tick();
    total++;
    if (rd_data_rf[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_rf_second act=%h exp=deadbeef", rd_data_rf[31:0]);
    end
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_wf_stored act=%h exp=deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_merge();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11223344; wr0_be = 4'hF;
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAAAAAA; wr0_be = 4'h3;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hBBBBBBBB; wr1_be = 4'h6;
    rd_addr = {5'd7, 5'd7};
    tick();
    total++;
    if (rd_data[31:0] !== 32'h11BBBBAA) begin
      bad++; $display("FAIL merge_bypass act=%h exp=11bbbbaa", rd_data[31:0]);
    end
    total++;
    if (rd_data_rf[63:32] !== 32'h11223344) begin
      bad++; $display("FAIL merge_rf_old act=%h exp=11223344", rd_data_rf[63:32]);
    end
    // Enabled write with no byte enables must leave the entry alone.
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h0; wr0_be = 4'h0;
    tick();
    idle_inputs();
    tick();
    total++;
    if (rd_data !== {32'h11BBBBAA, 32'h11BBBBAA}) begin
      bad++; $display("FAIL merge_stored act=%h exp=11bbbbaa11bbbbaa", rd_data);
    end
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h0000000A; wr0_be = 4'hF;
    wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h0000000B; wr1_be = 4'hF;
    tick();
    idle_inputs();
    rd_addr = {5'd11, 5'd10};
    tick();
    total++;
    if (rd_data !== {32'h0000000B, 32'h0000000A}) begin
      bad++; $display("FAIL parallel_write act=%h exp=0000000b0000000a", rd_data);
    end
  endtask

  task automatic test_zero();
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF; wr1_be = 4'hF;
    rd_addr = {5'd0, 5'd0};
    tick();
    total++;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL zero_bypass act=%h exp=0", rd_data); end
    idle_inputs();
    tick();
    total++;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL zero_later act=%h exp=0", rd_data); end
    total++;
    if (rd_data_rf !== 64'h0) begin bad++; $display("FAIL zero_rf act=%h exp=0", rd_data_rf); end
  endtask

  task automatic test_clear();
    for (int a = 1; a < 32; a++) begin
      wr0_en = 1'b1; wr0_addr = 5'(a); wr0_data = 32'(a); wr0_be = 4'hF;
      tick();
    end
    idle_inputs();
    // Write in the same cycle as the request still commits (visible via bypass).
    clr_req = 1'b1;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h77; wr1_be = 4'hF;
    rd_addr = {5'd2, 5'd31};
    tick();
    idle_inputs();
    total++;
    if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_start act=%b exp=1", clr_busy); end
    total++;
    if (rd_data !== {32'h77, 32'd31}) begin
      bad++; $display("FAIL clr_req_cycle act=%h exp=%h", rd_data, {32'h77, 32'd31});
    end
    for (int i = 1; i < 32; i++) begin
      wr0_en = (i == 10); wr0_addr = 5'd3; wr0_data = 32'h55; wr0_be = 4'hF;
      clr_req = (i == 20);
      tick();
      total++;
      if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_hold i=%0d act=%b exp=1", i, clr_busy); end
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL clr_rd_zero i=%0d act=%h exp=0", i, rd_data); end
    end
    idle_inputs();
    tick();
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_end act=%b exp=0", clr_busy); end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL clr_after a=%0d act=%h exp=0", a, rd_data); end
    end
  endtask

  task automatic test_reset_mid_clear();
    wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'hCAFE; wr0_be = 4'hF;
    tick();
    idle_inputs();
    rd_addr = {5'd20, 5'd20};
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    total++;
    if (clr_busy !== 1'b1) begin bad++; $display("FAIL midclr_busy act=%b exp=1", clr_busy); end
    rst = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL midclr_async_busy act=%b exp=0", clr_busy); end
    total++;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL midclr_async_rd act=%h exp=0", rd_data); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_addr = {5'd15, 5'd20};
    tick();
    total++;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL midclr_entries act=%h exp=0", rd_data); end
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL midclr_busy_after act=%b exp=0", clr_busy); end
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1234; wr0_be = 4'hF;
    rd_addr = {5'd0, 5'd1};
    tick();
    idle_inputs();
    rd_addr = {5'd0, 5'd9};
    tick();
    total++;
    if (rd_data[31:0] !== 32'h1234) begin
      bad++; $display("FAIL midclr_write act=%h exp=00001234", rd_data[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_merge();
    test_zero();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port CPU register file, successor to the single-write, two-read 32x32 register file in the processor datapath.
- Provides NUM_RD registered read ports and two write ports with byte enables.
- Provides write-first bypass, an optional hardwired zero register, and a sequenced synchronous bulk-clear engine with a busy flag.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 makes entry 0 read as zero and ignore writes.
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice i.
- rd_data  out  NUM_RD*DATA_W  registered read data; port i uses slice i.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr0_be  in  DATA_W/8  write port 0 byte enables.
- wr1_en  in  1  write port 1 enable.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- wr1_be  in  DATA_W/8  write port 1 byte enables.
- clr_req  in  1  single-cycle pulse that starts a bulk clear.
- clr_busy  out  1  high while the bulk clear is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - all entries = 0, all rd_data = 0, clr_busy = 0, FSM = IDLE, clear counter = 0.
  - Takes effect mid-clear or mid-write with no completion of the pending operation.
- Read latency is 1 cycle: rd_data[i] at edge N+1 reflects rd_addr[i] sampled at edge N.
- Read ports are fully independent; any number may hit the same address.
- Writes commit on the rising edge. Only bytes with be=1 are updated; an en with all be=0 is a no-op.
- Writes on both ports to the same address in the same cycle:
  - merge per byte; port 1 wins on bytes enabled by both ports.
  - Different addresses commit in parallel.
- ZERO_REG=1:
  - writes to address 0 are dropped.
  - reads of address 0 return 0, including under bypass.
- BYPASS=1, read address equal to a same-cycle write address (after zero filter):
  - rd_data = stored value with the merged write bytes overlaid (write-first).
- BYPASS=0: rd_data returns the pre-write stored value (read-first).
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR, cnt=0, clr_busy=1 from the next cycle.
  - CLEAR: one entry per cycle, mem[cnt]=0, cnt++.
  - CLEAR exit: when cnt reaches 2**ADDR_W-1, that entry is cleared, then -> IDLE and clr_busy=0 on the following edge.
  - Total busy duration is 2**ADDR_W cycles.
  - In CLEAR: all writes are ignored, all rd_data are registered as 0, and clr_req is ignored (no restart).
  - clr_req in the same cycle as a write in IDLE: the write commits, and clearing starts the next cycle.
- The counter is ADDR_W bits wide and wraps only at the exit point. No partial clears.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W/NUM_RD constants.
  - clear FSM state enum {IDLE, CLEAR}.
  - a byte-merge function (old, new, be).
- Sub-module regfile_rd_port: one instance per read port (generate loop).
  - Takes the address, both write ports, the storage read value and the clear state.
  - Produces the registered, bypassed, zero-filtered output.

Test Plan:
1. Reset then read all 32 addresses on 2 ports -> rd_data = 0x00000000 one cycle after each address.
2. wr0 addr 5 data 0xDEADBEEF be=0xF, rd0 addr 5 in the same cycle -> next cycle rd0 = 0xDEADBEEF (bypass). With BYPASS=0 -> rd0 = 0 then 0xDEADBEEF one cycle later.
3. Prior mem[7]=0x11223344; wr0 addr 7 data 0xAAAAAAAA be=0x3 and wr1 addr 7 data 0xBBBBBBBB be=0x6 -> mem[7] = 0x11BBBBAA; a same-cycle read returns 0x11BBBBAA.
4. wr1 addr 0 data 0xFFFFFFFF be=0xF, read addr 0 on both ports -> both return 0; a later read also returns 0.
5. Fill entries 1..31 with the address value, pulse clr_req:
   - clr_busy high for exactly 32 cycles.
   - a wr0 addr 3 data 0x55 issued during the clear is dropped.
   - after the clear, all reads return 0.
6. Deassert rst for one cycle at clear cycle 10 -> clr_busy = 0 immediately, all entries 0, and an IDLE write to addr 9 of 0x1234 then reads back 0x1234.
